// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit: single-outstanding instruction fetch with redirect/flush.     |
// | Optional macro FETCH_BTB_EN: take next PC / prediction from the BTB.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] BOOT_VECTOR = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        branch_request_i,
  input  logic [31:0] branch_pc_i,
  output logic        icache_rd_o,
  output logic [31:0] icache_pc_o,
  input  logic        icache_accept_i,
  input  logic        icache_valid_i,
  input  logic [63:0] icache_inst_i,
  input  logic        icache_error_i,
  input  logic        icache_page_fault_i,
  input  logic [31:0] next_pc_f_i,
  input  logic [1:0]  next_taken_f_i,
  output logic        fetch_valid_o,
  output logic [63:0] fetch_instr_o,
  output logic [31:0] fetch_pc_o,
  output logic        fetch_fault_fetch_o,
  output logic        fetch_fault_page_o,
  output logic [1:0]  fetch_pred_branch_o,
  input  logic        fetch_accept_i
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [1:0]  req_pred_q, req_pred_d;
  logic        valid_q, valid_d;
  logic [63:0] instr_q, instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        fault_fetch_q, fault_fetch_d;
  logic        fault_page_q, fault_page_d;
  logic [1:0]  pred_q, pred_d;

  logic [31:0] pc_aligned;
  logic [31:0] pc_next;
  logic [1:0]  pred_next;

  assign pc_aligned = {pc_q[31:3], 3'b000};

`ifdef FETCH_BTB_EN
  assign pc_next   = next_pc_f_i;
  assign pred_next = next_taken_f_i;
`else
  logic unused_btb;
  assign unused_btb = ^{next_pc_f_i, next_taken_f_i};
  assign pc_next    = pc_aligned + 32'd8;
  assign pred_next  = 2'b00;
`endif

  // Gated by rstn_i so no request is presented while reset is held.
  assign icache_rd_o = rstn_i & (state_q == ST_REQ) & ~branch_request_i;
  assign icache_pc_o = pc_aligned;

  assign fetch_valid_o       = valid_q;
  assign fetch_instr_o       = instr_q;
  assign fetch_pc_o          = out_pc_q;
  assign fetch_fault_fetch_o = fault_fetch_q;
  assign fetch_fault_page_o  = fault_page_q;
  assign fetch_pred_branch_o = pred_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    req_pred_d    = req_pred_q;
    valid_d       = valid_q;
    instr_d       = instr_q;
    out_pc_d      = out_pc_q;
    fault_fetch_d = fault_fetch_q;
    fault_page_d  = fault_page_q;
    pred_d        = pred_q;

    if (branch_request_i) begin
      pc_d    = branch_pc_i;
      valid_d = 1'b0;
    end

    case (state_q)
      ST_REQ: begin
        if (icache_rd_o && icache_accept_i) begin
          req_pc_d   = pc_q;
          req_pred_d = pred_next;
          pc_d       = pc_next;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (branch_request_i) begin
          state_d = icache_valid_i ? ST_REQ : ST_DROP;
        end else if (icache_valid_i) begin
          instr_d       = icache_inst_i;
          out_pc_d      = req_pc_q;
          pred_d        = req_pred_q;
          fault_fetch_d = icache_error_i;
          fault_page_d  = icache_page_fault_i;
          valid_d       = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (branch_request_i) begin
          state_d = ST_REQ;
        end else if (fetch_accept_i) begin
          valid_d = 1'b0;
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        // The stale response retires the outstanding request even if another
        // redirect lands in the same cycle; waiting longer would deadlock.
        if (icache_valid_i) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_REQ;
      pc_q          <= BOOT_VECTOR;
      req_pc_q      <= 32'd0;
      req_pred_q    <= 2'b00;
      valid_q       <= 1'b0;
      instr_q       <= 64'd0;
      out_pc_q      <= 32'd0;
      fault_fetch_q <= 1'b0;
      fault_page_q  <= 1'b0;
      pred_q        <= 2'b00;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      req_pred_q    <= req_pred_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      out_pc_q      <= out_pc_d;
      fault_fetch_q <= fault_fetch_d;
      fault_page_q  <= fault_page_d;
      pred_q        <= pred_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: scoreboard bench for fetch_unit with a transaction-level
// icache/decode model, directed scenarios and a randomized soak.
module tb_fetch_unit;
  localparam logic [31:0] BOOT = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        branch_request_i;
  logic [31:0] branch_pc_i;
  logic        icache_rd_o;
  logic [31:0] icache_pc_o;
  logic        icache_accept_i;
  logic        icache_valid_i;
  logic [63:0] icache_inst_i;
  logic        icache_error_i;
  logic        icache_page_fault_i;
  logic [31:0] next_pc_f_i;
  logic [1:0]  next_taken_f_i;
  logic        fetch_valid_o;
  logic [63:0] fetch_instr_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_fault_fetch_o;
  logic        fetch_fault_page_o;
  logic [1:0]  fetch_pred_branch_o;
  logic        fetch_accept_i;

  fetch_unit #(.BOOT_VECTOR(BOOT)) dut (
    .clk_i               (clk_i),
    .rstn_i              (rstn_i),
    .branch_request_i    (branch_request_i),
    .branch_pc_i         (branch_pc_i),
    .icache_rd_o         (icache_rd_o),
    .icache_pc_o         (icache_pc_o),
    .icache_accept_i     (icache_accept_i),
    .icache_valid_i      (icache_valid_i),
    .icache_inst_i       (icache_inst_i),
    .icache_error_i      (icache_error_i),
    .icache_page_fault_i (icache_page_fault_i),
    .next_pc_f_i         (next_pc_f_i),
    .next_taken_f_i      (next_taken_f_i),
    .fetch_valid_o       (fetch_valid_o),
    .fetch_instr_o       (fetch_instr_o),
    .fetch_pc_o          (fetch_pc_o),
    .fetch_fault_fetch_o (fetch_fault_fetch_o),
    .fetch_fault_page_o  (fetch_fault_page_o),
    .fetch_pred_branch_o (fetch_pred_branch_o),
    .fetch_accept_i      (fetch_accept_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] instr;
    logic        err;
    logic        pf;
    logic [1:0]  pred;
  } pkt_t;

  pkt_t        exp_q[$];
  logic [31:0] acc_log[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: architectural fetch PC plus the single in-flight request.
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_killed;
  int          m_wait;
  logic [31:0] m_req_pc;
  logic [1:0]  m_req_pred;

  int          p_acc, p_facc, p_br, lat_min, lat_max, p_jump;
  bit          br_force, pf_force, stray_force, btb_force;
  logic [31:0] br_target, btb_pc;
  logic [1:0]  btb_taken;
  int          cyc = 0;
  int          first_acc_cyc = -1;
  int          first_vld_cyc = -1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk32({name, "_valid"}, {31'd0, fetch_valid_o}, 32'd0);
    chk32({name, "_rd"}, {31'd0, icache_rd_o}, 32'd0);
    chk32({name, "_pc"}, fetch_pc_o, 32'd0);
    chk32({name, "_instr_or"}, {31'd0, |fetch_instr_o}, 32'd0);
    chk32({name, "_faults_pred"},
          {28'd0, fetch_fault_fetch_o, fetch_fault_page_o, fetch_pred_branch_o}, 32'd0);
  endtask

  task automatic model_reset();
    m_pc = BOOT;
    m_out = 0;
    m_killed = 0;
    exp_q.delete();
  endtask

  task automatic drive_inputs();
    icache_accept_i  = ($urandom_range(99) < p_acc);
    fetch_accept_i   = ($urandom_range(99) < p_facc);
    branch_request_i = br_force || ($urandom_range(99) < p_br);
    branch_pc_i      = br_force ? br_target : $urandom();
    br_force         = 0;
    if (btb_force) begin
      next_pc_f_i    = btb_pc;
      next_taken_f_i = btb_taken;
    end else if ($urandom_range(99) < p_jump) begin
      next_pc_f_i    = $urandom();
      next_taken_f_i = 2'($urandom_range(3));
    end else begin
      next_pc_f_i    = {m_pc[31:3], 3'b000} + 32'd8;
      next_taken_f_i = 2'b00;
    end
    icache_inst_i       = {$urandom(), $urandom()};
    icache_error_i      = ($urandom_range(9) == 0);
    icache_page_fault_i = ($urandom_range(9) == 0);
    icache_valid_i      = 1'b0;
    if (stray_force) begin
      icache_valid_i  = 1'b1;
      icache_accept_i = 1'b0;
      stray_force     = 0;
    end else if (m_out) begin
      if (m_wait == 0) begin
        icache_valid_i = 1'b1;
        if (pf_force) icache_page_fault_i = 1'b1;
        pf_force = 0;
      end else begin
        m_wait--;
      end
    end
  endtask

  // Called mid-cycle: decide what the coming edge does at transaction level.
  task automatic observe();
    pkt_t p;
    cyc++;
    if (fetch_valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (icache_valid_i && m_out) begin
      m_out = 0;
      if (!m_killed && !branch_request_i) begin
        p.pc = m_req_pc; p.instr = icache_inst_i; p.err = icache_error_i;
        p.pf = icache_page_fault_i; p.pred = m_req_pred;
        exp_q.push_back(p);
      end
    end
    if (icache_rd_o) begin
      chk32("single_outstanding", {31'd0, m_out}, 32'd0);
      chk32("req_addr", icache_pc_o, {m_pc[31:3], 3'b000});
      if (icache_accept_i) begin
        acc_log.push_back(icache_pc_o);
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        m_out = 1; m_killed = 0; m_req_pc = m_pc;
`ifdef FETCH_BTB_EN
        m_req_pred = next_taken_f_i;
        m_pc       = next_pc_f_i;
`else
        m_req_pred = 2'b00;
        m_pc       = {m_pc[31:3], 3'b000} + 32'd8;
`endif
        m_wait = lat_min + $urandom_range(lat_max - lat_min);
        btb_force = 0;
      end
    end
    if (branch_request_i) begin
      m_pc = branch_pc_i;
      if (m_out) m_killed = 1;
      exp_q.delete();
    end
  endtask

  task automatic step();
    drive_inputs();
    @(negedge clk_i);
    observe();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_accept(input string what, output logic [31:0] addr);
    int n = acc_log.size();
    int k = 0;
    while (acc_log.size() == n && k < 50) begin
      step();
      k++;
    end
    checks++;
    if (acc_log.size() == n) begin
      errors++;
      $display("FAIL %s_timeout: got no accepted request expected one within 50 cycles", what);
      addr = 32'hxxxx_xxxx;
    end else begin
      addr = acc_log[acc_log.size()-1];
    end
  endtask

  task automatic wait_valid(input string what);
    int k = 0;
    while (!fetch_valid_o && k < 20) begin
      step();
      k++;
    end
    chk32({what, "_valid_seen"}, {31'd0, fetch_valid_o}, 32'd1);
  endtask

  // Monitor: compares every delivered packet against the scoreboard queue.
  initial begin : monitor
    pkt_t prev;
    pkt_t e;
    bit   prev_hold;
    prev_hold = 0;
    forever begin
      @(negedge clk_i);
      #1;
      if (rstn_i !== 1'b1) begin
        prev_hold = 0;
        continue;
      end
      if (prev_hold) begin
        checks++;
        if (!fetch_valid_o || fetch_pc_o !== prev.pc || fetch_instr_o !== prev.instr ||
            fetch_fault_fetch_o !== prev.err || fetch_fault_page_o !== prev.pf ||
            fetch_pred_branch_o !== prev.pred) begin
          errors++;
          $display("FAIL hold_stable: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                   fetch_valid_o, fetch_pc_o, fetch_instr_o, prev.pc, prev.instr);
        end
      end
      if (fetch_valid_o) begin
        checks++;
        if (icache_rd_o !== 1'b0) begin
          errors++;
          $display("FAIL rd_while_holding: got %b expected 0", icache_rd_o);
        end
      end
      if (fetch_valid_o && fetch_accept_i && !branch_request_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_packet: got pc=%h expected no packet", fetch_pc_o);
        end else begin
          e = exp_q.pop_front();
          if (fetch_pc_o !== e.pc || fetch_instr_o !== e.instr || fetch_fault_fetch_o !== e.err ||
              fetch_fault_page_o !== e.pf || fetch_pred_branch_o !== e.pred) begin
            errors++;
            $display("FAIL packet: got pc=%h instr=%h err=%b pf=%b pred=%b expected pc=%h instr=%h err=%b pf=%b pred=%b",
                     fetch_pc_o, fetch_instr_o, fetch_fault_fetch_o, fetch_fault_page_o,
                     fetch_pred_branch_o, e.pc, e.instr, e.err, e.pf, e.pred);
          end
        end
      end
      prev_hold = fetch_valid_o && !fetch_accept_i && !branch_request_i;
      prev.pc = fetch_pc_o; prev.instr = fetch_instr_o; prev.err = fetch_fault_fetch_o;
      prev.pf = fetch_fault_page_o; prev.pred = fetch_pred_branch_o;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin : stimulus
    logic [31:0] a;
    bit          saw_valid;
    rstn_i = 1'b0;
    branch_request_i = 0; branch_pc_i = 0; icache_accept_i = 0; icache_valid_i = 0;
    icache_inst_i = 0; icache_error_i = 0; icache_page_fault_i = 0;
    next_pc_f_i = 0; next_taken_f_i = 0; fetch_accept_i = 0;
    p_acc = 100; p_facc = 100; p_br = 0; lat_min = 0; lat_max = 0; p_jump = 0;
    br_force = 0; pf_force = 0; stray_force = 0; btb_force = 0;
    br_target = 0; btb_pc = 0; btb_taken = 0;
    model_reset();

    // Reset state, then back-to-back fetch with 1-cycle icache.
    repeat (2) @(posedge clk_i);
    #1;
    chk_outputs_zero("reset");
    rstn_i = 1'b1;
    repeat (12) step();
    chk32("boot_fetch0", acc_log[0], 32'h8000_0000);
    chk32("boot_fetch1", acc_log[1], 32'h8000_0008);
    chk32("boot_fetch2", acc_log[2], 32'h8000_0010);
    chk32("min_latency", first_vld_cyc - first_acc_cyc, 32'd2);

    // Decode stall in HOLD.
    p_facc = 0;
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      step();
      chk32("stall_valid_rd", {30'd0, fetch_valid_o, icache_rd_o}, 32'b10);
    end
    p_facc = 100;

    // Redirect while WAIT, stale response arrives one cycle later.
    lat_min = 1; lat_max = 1;
    wait_accept("pre_branch", a);
    br_force = 1; br_target = 32'h8000_1004;
    saw_valid = 0;
    step();
    saw_valid |= fetch_valid_o;
    step();
    saw_valid |= fetch_valid_o;
    lat_min = 0; lat_max = 0;
    wait_accept("post_branch", a);
    chk32("branch_target_addr", a, 32'h8000_1000);
    chk32("no_stale_packet", {31'd0, saw_valid}, 32'd0);

    // Page-fault response forwarded, fetch continues at PC+8.
    br_force = 1; br_target = 32'h8000_2000;
    wait_accept("pf_req", a);
    chk32("pf_req_addr", a, 32'h8000_2000);
    pf_force = 1;
    wait_valid("pf");
    chk32("pf_flag", {31'd0, fetch_fault_page_o}, 32'd1);
    chk32("pf_pc", fetch_pc_o, 32'h8000_2000);
    wait_accept("pf_next", a);
    chk32("pf_next_addr", a, 32'h8000_2008);

`ifdef FETCH_BTB_EN
    btb_force = 1; btb_pc = 32'h8000_0200; btb_taken = 2'b01;
    wait_accept("btb_req", a);
    wait_valid("btb");
    chk32("btb_pred", {30'd0, fetch_pred_branch_o}, 32'd1);
    wait_accept("btb_next", a);
    chk32("btb_next_addr", a, 32'h8000_0200);
`endif

    // Asynchronous reset while WAIT.
    lat_min = 3; lat_max = 3;
    wait_accept("pre_reset", a);
    #2;
    rstn_i = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    lat_min = 0; lat_max = 0;
    p_acc = 0; stray_force = 1;
    step();
    step();
    chk32("stray_ignored", {31'd0, fetch_valid_o}, 32'd0);
    p_acc = 100;
    wait_accept("post_reset", a);
    chk32("restart_addr", a, BOOT);

    // PC wrap at the top of the address space.
    br_force = 1; br_target = 32'hFFFF_FFFC;
    wait_accept("wrap0", a);
    chk32("wrap_addr0", a, 32'hFFFF_FFF8);
    wait_accept("wrap1", a);
    chk32("wrap_addr1", a, 32'h0000_0000);

    // Randomized soak.
    p_acc = 70; p_facc = 60; p_br = 4; lat_min = 0; lat_max = 3; p_jump = 30;
    repeat (3000) step();

    // Drain: everything produced must have been delivered.
    p_br = 0; p_facc = 100; p_acc = 0;
    repeat (12) step();
    chk32("drain_queue", exp_q.size(), 32'd0);
    chk32("drain_outstanding", {31'd0, m_out}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter BOOT_VECTOR, default 32'h8000_0000, reset fetch PC.
REQ-002 SHALL have ports (clock and reset first):
- clk_i  in  1  single clock, all state on rising edge
- rstn_i  in  1  asynchronous active-low reset
- branch_request_i  in  1  redirect/flush pulse
- branch_pc_i  in  32  redirect target
- icache_rd_o  out  1  fetch request valid
- icache_pc_o  out  32  request address, bits [2:0]=0
- icache_accept_i  in  1  request accepted
- icache_valid_i  in  1  response valid
- icache_inst_i  in  64  response data, two instructions
- icache_error_i  in  1  bus error
- icache_page_fault_i  in  1  page fault
- next_pc_f_i  in  32  predicted next PC
- next_taken_f_i  in  2  predicted-taken per slot
- fetch_valid_o  out  1  fetch packet valid to decode
- fetch_instr_o  out  64  packet instructions
- fetch_pc_o  out  32  packet PC
- fetch_fault_fetch_o  out  1  packet bus error
- fetch_fault_page_o  out  1  packet page fault
- fetch_pred_branch_o  out  2  packet prediction
- fetch_accept_i  in  1  decode accepts packet

Function
REQ-003 SHALL hold at most one outstanding icache request; states REQ, WAIT, HOLD, DROP.
REQ-004 REQ: icache_rd_o = 1 unless branch_request_i; icache_pc_o = {pc_q[31:3],3'b000}; on icache_rd_o & icache_accept_i latch req_pc = pc_q and pred = next prediction, update pc_q to next PC, go WAIT.
REQ-005 WAIT: on icache_valid_i register instr, req_pc, pred, error, page_fault into output registers, set fetch_valid_o, go HOLD.
REQ-006 HOLD: fetch_valid_o = 1 with all packet outputs stable until fetch_accept_i; on fetch_accept_i clear fetch_valid_o next edge, go REQ.
REQ-007 Minimum latency: accept in cycle N, icache_valid_i in N+1 gives fetch_valid_o high from N+2.
REQ-008 branch_request_i in any state: pc_q <= branch_pc_i, fetch_valid_o cleared next edge.
REQ-009 Redirect transitions: REQ->REQ; HOLD->REQ; WAIT with icache_valid_i same cycle->REQ, response discarded; WAIT without icache_valid_i->DROP; DROP->DROP.
REQ-010 DROP: icache_rd_o = 0; icache_valid_i consumed and discarded, go REQ; no packet produced.
REQ-011 Redirect has priority over fetch_accept_i and icache_valid_i in the same cycle.
REQ-012 Faulted responses SHALL be forwarded with fetch_instr_o = icache_inst_i unchanged and the fault bits set; fetching continues.
REQ-013 pc_q SHALL wrap modulo 2^32 on increment.

Reset
REQ-014 rstn_i low: state = REQ, pc_q = BOOT_VECTOR, fetch_valid_o = 0, fetch_instr_o = 0, fetch_pc_o = 0, fault outputs = 0, fetch_pred_branch_o = 0, icache_rd_o = 0 while reset is asserted.
REQ-015 Reset asserted mid-operation SHALL abandon any outstanding request; a later stray icache_valid_i in REQ SHALL be ignored.

Configuration
REQ-016 Macro FETCH_BTB_EN defined: next PC = next_pc_f_i and latched pred = next_taken_f_i.
REQ-017 Macro FETCH_BTB_EN undefined: next PC = {pc_q[31:3],3'b000} + 8, pred = 2'b00, and next_pc_f_i / next_taken_f_i ignored.

Verification
REQ-018 Bench SHALL cover the following scenarios:
- Reset release, icache always accepting with 1-cycle response, fetch_accept_i = 1 -> icache_pc_o 8000_0000, 8000_0008, 8000_0010; packets in order with matching fetch_pc_o.
- fetch_accept_i held low 5 cycles in HOLD -> fetch_valid_o high and outputs stable, icache_rd_o = 0 throughout.
- branch_request_i with branch_pc_i = 8000_1004 while WAIT, response next cycle -> response dropped, next icache_pc_o = 8000_1000, no packet from stale response.
- icache_page_fault_i with response -> fetch_fault_page_o = 1 with fetch_pc_o of that request, next fetch proceeds at PC+8.
- FETCH_BTB_EN, next_pc_f_i = 8000_0200, next_taken_f_i = 2'b01 -> fetch_pred_branch_o = 01, next icache_pc_o = 8000_0200.
- rstn_i asserted in WAIT -> all outputs zero immediately, restart at BOOT_VECTOR.
